// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-unit types, IR field positions and PC offsets
package fetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    localparam int COND_MSB  = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_LSB = 20;
    localparam int RN_LSB    = 16;
    localparam int RD_LSB    = 12;

    localparam int PC_STEP        = 4;
    localparam int PC_READ_OFFSET = 8;

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - multicycle fetch unit owning PC and IR, req/ack to instruction memory
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_start,
    input  logic            pc_load,
    input  logic [XLEN-1:0] pc_target,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [3:0]      Cond,
    output logic [1:0]      Op,
    output logic [5:0]      Funct,
    output logic [3:0]      Rn,
    output logic [3:0]      Rd,
    output logic            instr_valid,
    output logic            busy,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc_plus8
);

    localparam logic [XLEN-1:0] RESET_PC_X = XLEN'(RESET_PC);
    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] READ_OFS   = XLEN'(PC_READ_OFFSET);

    fetch_state_t    state;
    logic            squash;
    logic [XLEN-1:0] target_aligned;

    assign target_aligned = {pc_target[XLEN-1:2], 2'b00};

    assign Cond  = instr[COND_MSB -: 4];
    assign Op    = instr[OP_LSB +: 2];
    assign Funct = instr[FUNCT_LSB +: 6];
    assign Rn    = instr[RN_LSB +: 4];
    assign Rd    = instr[RD_LSB +: 4];

    assign pc_plus8 = instr_pc + READ_OFS;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC_X;
            instr       <= '0;
            instr_pc    <= RESET_PC_X;
            mem_req     <= 1'b0;
            mem_addr    <= RESET_PC_X;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            squash      <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_start) begin
                        mem_addr <= pc_load ? target_aligned : pc;
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        squash   <= 1'b0;
                        state    <= WAIT;
                    end
                    if (pc_load) begin
                        pc <= target_aligned;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        // A redirect seen at any point of the fetch makes the returned word stale.
                        if (squash || pc_load) begin
                            if (pc_load) begin
                                pc <= target_aligned;
                            end
                        end else begin
                            instr       <= mem_rdata;
                            instr_pc    <= mem_addr;
                            pc          <= mem_addr + STEP;
                            instr_valid <= 1'b1;
                        end
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        squash  <= 1'b0;
                        state   <= IDLE;
                    end else if (pc_load) begin
                        squash <= 1'b1;
                        pc     <= target_aligned;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Multicycle fetch unit that drives the instruction fields the main-control decoder consumes: Cond, Op, Funct, Rd and Rn.
- Owns the PC and the instruction register (IR).
- Runs a req/ack handshake with a variable-latency instruction memory.
- Accepts fetch requests and PC redirects from the control FSM and datapath, and reports completion back to them.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_start  in  1  pulse from control FSM: fetch the instruction at PC.
- pc_load  in  1  redirect request (branch or write to R15).
- pc_target  in  XLEN  redirect address; bits [1:0] ignored and forced to 0.
- mem_req  out  1  memory read request, held until mem_ack.
- mem_addr  out  XLEN  word-aligned read address, stable while mem_req is high.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  XLEN  read data.
- instr  out  XLEN  current IR contents.
- Cond  out  4  instr[31:28].
- Op  out  2  instr[27:26].
- Funct  out  6  instr[25:20].
- Rn  out  4  instr[19:16].
- Rd  out  4  instr[15:12].
- instr_valid  out  1  one-cycle pulse when the IR is updated.
- busy  out  1  high while a fetch is outstanding.
- pc  out  XLEN  address of the next fetch.
- instr_pc  out  XLEN  address of the instruction held in the IR.
- pc_plus8  out  XLEN  instr_pc + 8 (R15 read value).

Behaviour:
- Reset (asynchronous, reset low):
  - state=IDLE, pc=RESET_PC, instr=0, instr_pc=RESET_PC.
  - mem_req=0, instr_valid=0, busy=0, squash=0, mem_addr=RESET_PC.
- Field outputs (Cond, Op, Funct, Rn, Rd) are purely combinational slices of the IR. pc_plus8 is combinational.
- IDLE state:
  - fetch_start=1: mem_addr<=pc (or aligned pc_target if pc_load=1 the same cycle, in which case pc<=aligned target too); mem_req<=1, busy<=1, go to WAIT.
  - pc_load=1 alone: pc<=aligned pc_target; stay in IDLE.
- WAIT state:
  - mem_req stays high and mem_addr stays constant until mem_ack. fetch_start is ignored (no queueing).
  - pc_load=1 without ack: set squash; latch the aligned target into pc immediately.
  - pc_load=1 in the same cycle as mem_ack: treated as squash.
  - mem_ack=1, not squashed: instr<=mem_rdata, instr_pc<=mem_addr, pc<=mem_addr+4, instr_valid<=1 for exactly the next cycle. Then mem_req<=0, busy<=0, go to IDLE.
  - mem_ack=1, squashed (squash flag set, or pc_load this cycle): discard data; instr, instr_pc and instr_valid are unchanged; pc holds the redirect target (a pc_load in the ack cycle loads the target then). Clear squash, go to IDLE. The control FSM must reissue fetch_start.
- Minimum latency: fetch_start in cycle N, mem_req in N+1, ack in N+1 gives instr_valid in N+2.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC + 4 wraps to 0.
- mem_ack while in IDLE is ignored and has no state effect.
- Reset asserted mid-WAIT: the fetch is abandoned immediately. After release, the first ack (if the memory still returns one) is ignored because the state is IDLE.
- instr_valid and the IR update occur only on a non-squashed ack.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum {IDLE, WAIT};
  - field position constants: COND_MSB=31, OP_LSB=26, FUNCT_LSB=20, RN_LSB=16, RD_LSB=12;
  - PC_STEP=4, PC_READ_OFFSET=8.
- No sub-module is needed. The field slicer may optionally be split into instr_fields (combinational) for reuse by the decoder bench.

Test Plan:
- Reset then fetch_start, mem_ack 1 cycle later with rdata 32'hE281_1004 -> instr_valid pulse; Cond=4'hE, Op=2'b00, Funct=6'b101000, Rn=1, Rd=1; instr_pc=0, pc=4, pc_plus8=8.
- Memory latency 5 cycles -> mem_req held 5 cycles, mem_addr constant at 4, busy high throughout; instr_valid asserted exactly once.
- pc_load with target 32'h0000_0103 in WAIT, then ack -> IR and instr_valid unchanged; pc=32'h100; next fetch_start gives mem_addr=32'h100.
- fetch_start and pc_load (target 32'h40) in the same IDLE cycle -> mem_addr=32'h40; after ack, instr_pc=32'h40 and pc=32'h44.
- PC at 32'hFFFF_FFFC, fetch completes -> pc=0 (wrap); pc_plus8=32'h0000_0004.
- Reset driven low during WAIT with a late ack -> all outputs return to reset values; the late ack produces no instr_valid.
